// File: rtl/spi_slave.sv
// SPI slave front end: deserialises MOSI frames into rx_data/rx_valid and serialises RAM read data on MISO.
// Optional macro SPI_SLAVE_RD_ORDER_EN drops read frames whose command bits disagree with the routed state.
module spi_slave #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure; tx_valid is
  // honoured only while a completed rd-data frame is waiting for its byte.
  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               miso_q, miso_d;
  logic               rd_addr_seen_q, rd_addr_seen_d;
  logic [DATA_W-1:0]  tx_byte_q, tx_byte_d;
  logic               rd_wait_q, rd_wait_d;
  logic               tx_busy_q, tx_busy_d;
  logic [IDX_W-1:0]   tx_idx_q, tx_idx_d;
  logic               frame_ok;
  logic               tx_last;

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_last  = tx_busy_q && (tx_idx_q == IDX_LAST);

  always_comb begin
`ifdef SPI_SLAVE_RD_ORDER_EN
    frame_ok = 1'b1;
    if (state_q == READ_ADD)  frame_ok = (shift_q[FRAME_W-1 -: 2] == 2'b10);
    if (state_q == READ_DATA) frame_ok = (shift_q[FRAME_W-1 -: 2] == 2'b11);
`else
    frame_ok = 1'b1;
`endif
  end

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = miso_q;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_byte_d      = tx_byte_q;
    rd_wait_d      = rd_wait_q;
    tx_busy_d      = tx_busy_q;
    tx_idx_d       = tx_idx_q;

    case (state_q)
      IDLE: begin
        if (!SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        shift_d = {shift_q[FRAME_W-2:0], MOSI};
        cnt_d   = CNT_W'(1);
        if (!MOSI)               state_d = WRITE;
        else if (rd_addr_seen_q) state_d = READ_DATA;
        else                     state_d = READ_ADD;
      end
      default: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (frame_ok) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
          end
          if (state_q == READ_ADD && frame_ok) rd_addr_seen_d = 1'b1;
          if (state_q == READ_DATA && frame_ok) rd_wait_d = 1'b1;
          else                                  state_d   = IDLE;
        end else if (rd_wait_q) begin
          if (tx_valid) begin
            tx_byte_d = tx_data;
            tx_busy_d = 1'b1;
            rd_wait_d = 1'b0;
            tx_idx_d  = '0;
          end
        end else if (tx_busy_q) begin
          if (tx_last) begin
            miso_d         = 1'b0;
            tx_busy_d      = 1'b0;
            rd_addr_seen_d = 1'b0;
            state_d        = IDLE;
          end else begin
            miso_d    = tx_byte_q[DATA_W-1];
            tx_byte_d = {tx_byte_q[DATA_W-2:0], 1'b0};
            tx_idx_d  = tx_idx_q + IDX_W'(1);
          end
        end else begin
          shift_d = {shift_q[FRAME_W-2:0], MOSI};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
    endcase

    // Deselect aborts everything except the final MISO park, which ends the byte normally.
    if (state_q != IDLE && SS_n && !tx_last) begin
      state_d        = IDLE;
      cnt_d          = '0;
      tx_idx_d       = '0;
      miso_d         = 1'b0;
      rx_valid_d     = 1'b0;
      rx_data_d      = rx_data_q;
      rd_addr_seen_d = rd_addr_seen_q;
      rd_wait_d      = 1'b0;
      tx_busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      cnt_q          <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_byte_q      <= '0;
      rd_wait_q      <= 1'b0;
      tx_busy_q      <= 1'b0;
      tx_idx_q       <= '0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_byte_q      <= tx_byte_d;
      rd_wait_q      <= rd_wait_d;
      tx_busy_q      <= tx_busy_d;
      tx_idx_q       <= tx_idx_d;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: frame decode, read return, abort, reset and command ordering.
`timescale 1ns/1ps
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_pass = 0;
  int n_total = 0;
  int rx_pulses = 0;
  int exp_pulses = 0;
  int miso_err = 0;
  logic chk_miso_zero = 1'b0;

  logic [9:0] exp_q[$];
  logic [7:0] miso_q[$];
  logic [9:0] mon_exp;

  spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every rx_valid pulse must match the oldest expected frame
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      rx_pulses++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL rx_unexpected: rx_data=%h with no frame expected", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_data !== mon_exp)
          $display("FAIL rx_data: got %h expected %h", rx_data, mon_exp);
        else
          n_pass++;
      end
    end
    if (chk_miso_zero && MISO !== 1'b0) miso_err++;
  end

  // Driver tasks: all entered and left #1 after a rising edge
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [9:0] f, input bit hold_low, input bit exp_valid);
    if (exp_valid) begin
      exp_q.push_back(f);
      exp_pulses++;
    end
    SS_n = 1'b0;
    @(posedge clk); #1;
    MOSI = f[9];
    for (int i = 8; i >= 0; i--) begin
      @(posedge clk); #1;
      MOSI = f[i];
    end
    @(posedge clk); #1;
    n_total++;
    if (rx_valid !== 1'b0) $display("FAIL early_valid: rx_valid=%b at k+10 expected 0 (frame %h)", rx_valid, f);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (rx_valid !== exp_valid) $display("FAIL valid_k11: rx_valid=%b expected %b (frame %h)", rx_valid, exp_valid, f);
    else n_pass++;
    if (!hold_low) SS_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    idle(3);
    n_total++;
    if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000)
      $display("FAIL reset_outputs: MISO=%b rx_valid=%b rx_data=%h expected 0/0/000", MISO, rx_valid, rx_data);
    else n_pass++;
    n_total++;
    if (dut.state_q !== 3'd0 || dut.rd_addr_seen_q !== 1'b0)
      $display("FAIL reset_state: state=%0d rd_addr_seen=%b expected 0/0", dut.state_q, dut.rd_addr_seen_q);
    else n_pass++;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_write_pair;
    chk_miso_zero = 1'b1;
    tx_valid = 1'b1; tx_data = 8'hFF;
    send_frame(10'h0A5, 0, 1);
    idle(2);
    send_frame(10'h13C, 0, 1);
    idle(2);
    tx_valid = 1'b0;
    chk_miso_zero = 1'b0;
    n_total++;
    if (miso_err != 0) $display("FAIL write_miso: %0d cycles with MISO high, expected 0", miso_err);
    else n_pass++;
    n_total++;
    if (dut.rd_addr_seen_q !== 1'b0) $display("FAIL write_rd_seen: got %b expected 0", dut.rd_addr_seen_q);
    else n_pass++;
  endtask

  task automatic test_read_pair;
    logic [7:0] got;
    logic [7:0] want;
    send_frame(10'h280, 0, 1);
    idle(2);
    n_total++;
    if (dut.rd_addr_seen_q !== 1'b1) $display("FAIL rd_addr_set: got %b expected 1", dut.rd_addr_seen_q);
    else n_pass++;
    send_frame(10'h3FF, 1, 1);
    miso_q.push_back(8'hC3);
    tx_valid = 1'b1; tx_data = 8'hC3;
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_data = 8'h00;
    n_total++;
    if (MISO !== 1'b0) $display("FAIL miso_pre: got %b at edge m expected 0", MISO);
    else n_pass++;
    got = 8'h00;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      got = {got[6:0], MISO};
    end
    want = miso_q.pop_front();
    n_total++;
    if (got !== want) $display("FAIL miso_byte: got %h expected %h", got, want);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (MISO !== 1'b0 || dut.rd_addr_seen_q !== 1'b0 || dut.state_q !== 3'd0)
      $display("FAIL read_end: MISO=%b rd_addr_seen=%b state=%0d expected 0/0/0", MISO, dut.rd_addr_seen_q, dut.state_q);
    else n_pass++;
    SS_n = 1'b1;
    idle(2);
  endtask

  task automatic test_abort;
    logic [9:0] f;
    int pulses_before;
    f = 10'h155;
    pulses_before = rx_pulses;
    SS_n = 1'b0;
    @(posedge clk); #1;
    MOSI = f[9];
    for (int i = 8; i >= 4; i--) begin
      @(posedge clk); #1;
      MOSI = f[i];
    end
    @(posedge clk); #1;
    SS_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (dut.state_q !== 3'd0) $display("FAIL abort_state: state=%0d expected 0", dut.state_q);
    else n_pass++;
    idle(12);
    n_total++;
    if (rx_pulses != pulses_before) $display("FAIL abort_valid: %0d pulses expected %0d", rx_pulses, pulses_before);
    else n_pass++;
    send_frame(10'h0FF, 0, 1);
    idle(2);
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] f;
    send_frame(10'h280, 0, 1);
    idle(2);
    f = 10'h3C3;
    SS_n = 1'b0;
    @(posedge clk); #1;
    MOSI = f[9];
    for (int i = 8; i >= 5; i--) begin
      @(posedge clk); #1;
      MOSI = f[i];
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    SS_n = 1'b1;
    #1;
    n_total++;
    if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000)
      $display("FAIL midrst_outputs: MISO=%b rx_valid=%b rx_data=%h expected 0/0/000", MISO, rx_valid, rx_data);
    else n_pass++;
    n_total++;
    if (dut.state_q !== 3'd0 || dut.rd_addr_seen_q !== 1'b0)
      $display("FAIL midrst_state: state=%0d rd_addr_seen=%b expected 0/0", dut.state_q, dut.rd_addr_seen_q);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send_frame(10'h0A5, 0, 1);
    idle(2);
  endtask

  task automatic test_ordering;
`ifdef SPI_SLAVE_RD_ORDER_EN
    send_frame(10'h3AA, 0, 0);
    idle(2);
    n_total++;
    if (dut.rd_addr_seen_q !== 1'b0 || dut.state_q !== 3'd0)
      $display("FAIL order_rdadd: rd_addr_seen=%b state=%0d expected 0/0", dut.rd_addr_seen_q, dut.state_q);
    else n_pass++;
    send_frame(10'h280, 0, 1);
    idle(2);
    chk_miso_zero = 1'b1;
    miso_err = 0;
    send_frame(10'h2AA, 0, 0);
    tx_valid = 1'b1; tx_data = 8'hFF;
    idle(12);
    tx_valid = 1'b0;
    chk_miso_zero = 1'b0;
    n_total++;
    if (miso_err != 0 || dut.state_q !== 3'd0)
      $display("FAIL order_rddata: MISO high %0d cycles state=%0d expected 0/0", miso_err, dut.state_q);
    else n_pass++;
`else
    send_frame(10'h3AA, 0, 1);
    idle(2);
    n_total++;
    if (dut.rd_addr_seen_q !== 1'b1 || dut.state_q !== 3'd0)
      $display("FAIL order_rdadd: rd_addr_seen=%b state=%0d expected 1/0", dut.rd_addr_seen_q, dut.state_q);
    else n_pass++;
`endif
  endtask

  task automatic test_back_to_back;
    logic [9:0] f;
    send_frame(10'h155, 1, 1);
    send_frame(10'h0F0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      f = 10'($urandom_range(0, 511));
      send_frame(f, (i != 3), 1);
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_write_pair();
    test_read_pair();
    test_abort();
    test_reset_mid_frame();
    test_ordering();
    test_back_to_back();
    n_total++;
    if (rx_pulses != exp_pulses || exp_q.size() != 0 || miso_q.size() != 0)
      $display("FAIL final_counts: pulses=%0d expected %0d, %0d frames and %0d bytes left unconsumed",
               rx_pulses, exp_pulses, exp_q.size(), miso_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
